// File: rtl/dso_pkg.sv
// Types and constants shared by the oscilloscope acquisition and display blocks.
package dso_pkg;

    localparam int SAMPLE_W = 12;
    localparam int SCREEN_W = 640;

    typedef enum logic [1:0] {
        ARM       = 2'd0,
        WAIT_TRIG = 2'd1,
        CAPTURE   = 2'd2,
        DONE      = 2'd3
    } capture_state_t;

endpackage

// File: rtl/minmax_tracker.sv
// Running min/max over one captured record, plus the registered mid-level (min+max)/2.
module minmax_tracker
    import dso_pkg::*;
#(
    parameter int DATA_W = SAMPLE_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              en_i,
    input  logic              latch_i,
    input  logic [DATA_W-1:0] sample_i,
    output logic [DATA_W-1:0] mean_o
);

    logic [DATA_W-1:0] min_q, min_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [DATA_W-1:0] mean_q, mean_d;
    logic [DATA_W:0]   sum;

    // clear_i with en_i seeds both extremes from the first sample of a record
    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (clear_i) begin
            min_d = '1;
            max_d = '0;
        end
        if (en_i) begin
            if (clear_i || (sample_i < min_q)) min_d = sample_i;
            if (clear_i || (sample_i > max_q)) max_d = sample_i;
        end
    end

    assign sum = {1'b0, min_q} + {1'b0, max_q};

    always_comb begin
        mean_d = mean_q;
        if (latch_i) mean_d = sum[DATA_W:1];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            min_q  <= '1;
            max_q  <= '0;
            mean_q <= '0;
        end else begin
            min_q  <= min_d;
            max_q  <= max_d;
            mean_q <= mean_d;
        end
    end

    assign mean_o = mean_q;

endmodule

// File: rtl/trigger_capture.sv
// Waveform-buffer writer: arms below trig_level-HYST, triggers on a rising crossing
// (or after AUTO_TIMEOUT samples), writes DEPTH samples, then holds until released.
module trigger_capture
    import dso_pkg::*;
#(
    parameter int DATA_W       = SAMPLE_W,
    parameter int DEPTH        = SCREEN_W,
    parameter int ADDR_W       = 10,
    parameter int HYST         = 16,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              release_i,  // "release" is a reserved word
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              capture_done,
    output logic              auto_trig,
    output logic [DATA_W-1:0] mean,
    output capture_state_t    dbg_state
);

    localparam int                CNT_W    = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [DATA_W-1:0] HYST_V   = DATA_W'(HYST);
    localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(AUTO_TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ADDR_PRE = ADDR_W'(DEPTH - 2);

    capture_state_t    state_q, state_d;
    logic [CNT_W-1:0]  to_cnt_q, to_cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              done_q, done_d;
    logic              auto_q, auto_d;

    logic [DATA_W-1:0] lo;
    logic              searching;
    logic              arm_hit;
    logic              real_trig;
    logic              start;
    logic              rec_write;

    assign lo        = (trig_level >= HYST_V) ? (trig_level - HYST_V) : '0;
    assign searching = (state_q == ARM) || (state_q == WAIT_TRIG);
    assign arm_hit   = adc_valid && (state_q == ARM) && (data_in < lo);
    assign real_trig = adc_valid && (state_q == WAIT_TRIG) && (data_in >= trig_level);
    // The timeout fires on the sample that brings the count up to AUTO_TIMEOUT
    assign start     = real_trig || (searching && adc_valid && (to_cnt_q == TO_LAST));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ARM;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARM: begin
                if (start)        state_d = CAPTURE;
                else if (arm_hit) state_d = WAIT_TRIG;
            end
            WAIT_TRIG: if (start) state_d = CAPTURE;
            CAPTURE:   if (adc_valid && (wr_addr_q == ADDR_PRE)) state_d = DONE;
            DONE:      if (release_i) state_d = ARM;
            default:   state_d = ARM;
        endcase
    end

    always_comb begin
        rec_write = (state_q == CAPTURE) && adc_valid;
        wr_en_d   = start || rec_write;
        wr_addr_d = wr_addr_q;
        if (start)          wr_addr_d = '0;
        else if (rec_write) wr_addr_d = wr_addr_q + ADDR_W'(1);
        wr_data_d = wr_en_d ? data_in : wr_data_q;
        auto_d    = start ? ~real_trig : auto_q;
        done_d    = (state_q == DONE) && !release_i;
        to_cnt_d  = to_cnt_q;
        if (!searching || start) to_cnt_d = '0;
        else if (adc_valid)      to_cnt_d = to_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            to_cnt_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            auto_q    <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            auto_q    <= auto_d;
        end
    end

    minmax_tracker #(
        .DATA_W (DATA_W)
    ) u_minmax (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (start),
        .en_i     (wr_en_d),
        .latch_i  (state_q == DONE),
        .sample_i (data_in),
        .mean_o   (mean)
    );

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign capture_done = done_q;
    assign auto_trig    = auto_q;
    assign dbg_state    = state_q;

endmodule

// File: doc/trigger_capture.md
# trigger_capture

Acquisition-side controller for the oscilloscope waveform buffer. It watches the ADC sample stream, detects a rising-edge crossing of the trigger level with hysteresis, and writes one screen-width record of samples into the dual-port waveform RAM. It then holds the record and reports its mid-level to `voltage_scale` until the VGA display side releases the frame. It is the writer end of the same buffer that the display path reads by `xaxis`.

## Interface
Parameters:
- `DATA_W`, 12: ADC sample width.
- `DEPTH`, 640: samples per record; equals the visible pixel columns.
- `ADDR_W`, 10: write address width; must satisfy 2^ADDR_W ≥ DEPTH.
- `HYST`, 16: arming hysteresis, in LSBs below the trigger level.
- `AUTO_TIMEOUT`, 4096: accepted samples without a trigger before a forced capture.

Ports:
- `clock`  in  1: single system clock; all logic is on its rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `adc_valid`  in  1: one-cycle strobe; `data_in` holds a new sample.
- `data_in`  in  DATA_W: unsigned ADC sample.
- `trig_level`  in  DATA_W: trigger threshold, e.g. `{button_counter,8'd0}`.
- `release`  in  1: one-cycle pulse from the display when the frame has been drawn.
- `wr_en`  out  1: RAM write strobe.
- `wr_addr`  out  ADDR_W: RAM write address.
- `wr_data`  out  DATA_W: RAM write data.
- `capture_done`  out  1: record complete and stable (the `fifo_full` equivalent).
- `auto_trig`  out  1: the last record was forced by timeout.
- `mean`  out  DATA_W: (min+max)/2 of the last record.

## Operation
States: ARM → WAIT_TRIG → CAPTURE → DONE → ARM. The state advances only on `adc_valid` cycles, except DONE, which waits for `release`.

- **ARM:** wait for a sample < `lo`, where `lo` = `trig_level` − HYST, saturated at 0. Such a sample moves the FSM to WAIT_TRIG.
- **WAIT_TRIG:** a sample ≥ `trig_level` is the trigger sample. Go to CAPTURE and write that sample at address 0.
- **Timeout:** a timeout counter counts accepted samples in ARM and WAIT_TRIG and clears on leaving them. When it reaches AUTO_TIMEOUT, the current sample becomes the trigger sample and `auto_trig` is set. An actual trigger in the same cycle wins, and `auto_trig` is cleared.
- **CAPTURE:** each accepted sample is written at the next address (0..DEPTH−1), and running min and max are updated. The write at address DEPTH−1 moves the FSM to DONE.
- **DONE:** no writes. `mean` = (min+max)>>1, computed with a DATA_W+1-bit sum. `release` moves the FSM to ARM and clears `capture_done`.
- **Ignored inputs:** `release` outside DONE is ignored, and `adc_valid` in DONE is ignored.
- **Level changes:** a `trig_level` change takes effect on the next sample compare. A record in progress is not affected.
- **Reset:** asynchronous `reset` low at any time forces ARM. It zeroes the counters, `wr_en`, `wr_addr`, `wr_data`, `capture_done`, `auto_trig` and `mean`, and min/max go to their extremes. A partial record is abandoned and no further writes occur.

## Timing
- All outputs are registered.
- `wr_en`/`wr_addr`/`wr_data` are valid exactly one clock after the `adc_valid` cycle of the sample. `wr_en` is high for one cycle per sample.
- `capture_done` rises on the clock after the final write's `wr_en` cycle.
- `mean` is valid on the same cycle that `capture_done` rises and is held until the next DONE.
- `capture_done` falls on the clock after the `release` cycle, and that sample is the earliest one ARM can accept.
- Back-to-back `adc_valid` every cycle is supported, with no bubbles.
- `wr_addr` holds DEPTH−1 after a record and returns to 0 on the next trigger write. It never reaches DEPTH.

## Structure
- Shared package `dso_pkg`:
  - `capture_state_t` enum (ARM, WAIT_TRIG, CAPTURE, DONE).
  - `SAMPLE_W` = 12 and `SCREEN_W` = 640 constants, shared with the display/VGA blocks.
- Sub-module `minmax_tracker`: clear, sample enable, running min/max, and the `mean` output. Everything else stays in `trigger_capture`.

## Test plan
- **Ramp trigger:** `trig_level`=1280; ramp from 1000 in +40 steps, one sample per 10 clocks. Required: first `wr_en` with `wr_addr`=0, `wr_data`=1280; 640 writes; `capture_done`=1; `auto_trig`=0.
- **Mean:** triangle 1000↔1480 captured. Required: `mean`=1240 at `capture_done`.
- **Hold and release:** samples continue while in DONE. Required: no `wr_en`. A `release` pulse drops `capture_done` next clock; the FSM re-arms and requires a sample < 1264 before retriggering.
- **Auto trigger:** constant `data_in`=100 with `trig_level`=3840. Required: the capture starts on the 4096th accepted sample; `auto_trig`=1; `mean`=100.
- **Hysteresis:** with `trig_level`=1280, a signal wandering 1270..1300. Required: no trigger; a dip to 1260 followed by 1280 triggers.
- **Reset mid-capture:** `reset` low at address 300. Required: all outputs 0 immediately. After release of reset, the next record starts at address 0 only after a new arm and trigger.
